// File: rtl/nsa_pkg.sv
// Shared types and constants for the nibble-serial adder arbiter.
package nsa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIBBLE = 4;

    // Ceiling log2, used to size the nibble index counter.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/add_nibble_ci.sv
// 4-bit ripple-carry adder with carry-in; also exposes the carry into bit 3
// so the controller can derive signed overflow on the top nibble.
module add_nibble_ci
    import nsa_pkg::*;
(
    input  logic [NIBBLE-1:0] a,
    input  logic [NIBBLE-1:0] b,
    input  logic              cin,
    output logic [NIBBLE-1:0] sum,
    output logic              cout,
    output logic              c3
);

    logic [NIBBLE:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < NIBBLE; i++) begin : g_bit
        full_adder_1bit u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (sum[i]),
            .co (c[i+1])
        );
    end

    assign cout = c[NIBBLE];
    assign c3   = c[NIBBLE-1];

endmodule

// File: rtl/full_adder_1bit.sv
// Single-bit full adder, the building block of the nibble ripple adder.
module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/nibble_serial_add_arbiter.sv
// Two-requester round-robin front end sharing one 4-bit adder slice that
// computes WORDS-nibble additions LSB nibble first, one nibble per cycle.
module nibble_serial_add_arbiter
    import nsa_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic [NIBBLE*WORDS-1:0] req0_a,
    input  logic [NIBBLE*WORDS-1:0] req0_b,
    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic [NIBBLE*WORDS-1:0] req1_a,
    input  logic [NIBBLE*WORDS-1:0] req1_b,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [NIBBLE*WORDS-1:0] res_sum,
    output logic                    res_carry,
    output logic                    res_ovf,
    output logic                    res_id,
    output logic                    busy
);

    localparam int W  = NIBBLE * WORDS;
    localparam int IW = (WORDS > 1) ? clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    state_t          state;
    state_t          state_nx;
    logic            grant0;
    logic            grant1;
    logic            accept;
    logic            rr;          // 0: req0 preferred on a tie, 1: req1 preferred
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [W-1:0]    work_sum;
    logic [W-1:0]    sum_next;
    logic [IW-1:0]   idx;
    logic            carry;
    logic [NIBBLE-1:0] a_nib;
    logic [NIBBLE-1:0] b_nib;
    logic [NIBBLE-1:0] nib_sum;
    logic            nib_cout;
    logic            nib_c3;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state, round-robin grant and status outputs; readies only in IDLE.
    always_comb begin
        state_nx  = state;
        grant0    = 1'b0;
        grant1    = 1'b0;
        res_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (!rst) begin
                    if (req0_valid && (!req1_valid || !rr)) begin
                        grant0 = 1'b1;
                    end else if (req1_valid) begin
                        grant1 = 1'b1;
                    end
                    if (grant0 || grant1) begin
                        state_nx = RUN;
                    end
                end
            end
            RUN: begin
                busy = 1'b1;
                if (idx == LAST) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign accept     = grant0 | grant1;

    // Select the operand nibbles at the current index and merge the new sum nibble.
    always_comb begin
        a_nib    = '0;
        b_nib    = '0;
        sum_next = work_sum;
        for (int k = 0; k < WORDS; k++) begin
            if (idx == IW'(k)) begin
                a_nib = a_reg[k*NIBBLE +: NIBBLE];
                b_nib = b_reg[k*NIBBLE +: NIBBLE];
                sum_next[k*NIBBLE +: NIBBLE] = nib_sum;
            end
        end
    end

    add_nibble_ci u_add (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry),
        .sum  (nib_sum),
        .cout (nib_cout),
        .c3   (nib_c3)
    );

    // Operand capture, nibble-serial accumulation and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            work_sum  <= '0;
            idx       <= '0;
            carry     <= 1'b0;
            rr        <= 1'b0;
            res_sum   <= '0;
            res_carry <= 1'b0;
            res_ovf   <= 1'b0;
            res_id    <= 1'b0;
        end else if (accept) begin
            a_reg    <= grant1 ? req1_a : req0_a;
            b_reg    <= grant1 ? req1_b : req0_b;
            res_id   <= grant1;
            rr       <= grant0;
            carry    <= 1'b0;
            idx      <= '0;
            work_sum <= '0;
        end else if (state == RUN) begin
            work_sum <= sum_next;
            carry    <= nib_cout;
            if (idx == LAST) begin
                // Publish only complete results so res_sum holds between operations.
                res_sum   <= sum_next;
                res_carry <= nib_cout;
                res_ovf   <= nib_c3 ^ nib_cout;
                idx       <= '0;
            end else begin
                idx <= idx + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_add_arbiter.sv
// Scoreboard bench for nibble_serial_add_arbiter with WORDS=4.
module tb_nibble_serial_add_arbiter;

    localparam int WORDS = 4;
    localparam int W     = 16;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         carry;
        logic         ovf;
        logic         id;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         res_valid, res_ready, res_carry, res_ovf, res_id, busy;
    logic [W-1:0] res_sum;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   acc_cyc;
    exp_t sb[$];

    nibble_serial_add_arbiter #(.WORDS(WORDS)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_sum    (res_sum),
        .res_carry  (res_carry),
        .res_ovf    (res_ovf),
        .res_id     (res_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic id, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] full;
        exp_t e;
        full    = {1'b0, a} + {1'b0, b};
        e.sum   = full[W-1:0];
        e.carry = full[W];
        e.ovf   = (a[W-1] == b[W-1]) && (e.sum[W-1] != a[W-1]);
        e.id    = id;
        return e;
    endfunction

    // Advance one clock; land 1 time unit after the edge and check ready exclusivity.
    task automatic step();
        @(posedge clk);
        #1;
        tests++;
        if ((req0_ready && req1_ready) || (busy && (req0_ready || req1_ready))) begin
            fails++;
            $display("FAIL ready_excl: r0=%b r1=%b busy=%b, want at most one ready and none while busy",
                     req0_ready, req1_ready, busy);
        end
    endtask

    task automatic issue(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input exp_t e, output logic ok);
        ok = 1'b0;
        if (id == 1'b0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end
        #1;
        for (int i = 0; i < 60 && !ok; i++) begin
            if ((id == 1'b0 && req0_ready) || (id == 1'b1 && req1_ready)) ok = 1'b1;
            else step();
        end
        if (ok) begin
            acc_cyc = cyc;
            sb.push_back(e);
            step();
        end else begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: requester %0d not granted, want grant within 60 cycles", id);
        end
        if (id == 1'b0) req0_valid = 1'b0;
        else            req1_valid = 1'b0;
    endtask

    task automatic wait_valid(output logic ok);
        for (int i = 0; i < 40 && !res_valid; i++) step();
        ok = res_valid;
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL result_timeout: res_valid=0, want 1 within 40 cycles");
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic ok;
        exp_t e;
        do_reset();
        tests++;
        if ({req0_ready, req1_ready, res_valid, res_sum, res_carry, res_ovf, res_id, busy} !== '0) begin
            fails++;
            $display("FAIL reset_init: sum=%h v=%b c=%b o=%b id=%b busy=%b, want all 0",
                     res_sum, res_valid, res_carry, res_ovf, res_id, busy);
        end
        res_ready = 1'b0;
        issue(1'b1, 16'h8001, 16'h8001, model(1'b1, 16'h8001, 16'h8001), ok);
        wait_valid(ok);
        e = sb.pop_front();
        tests++;
        if (res_sum !== e.sum || res_carry !== e.carry || res_ovf !== e.ovf || res_id !== e.id) begin
            fails++;
            $display("FAIL reset_pre: got %h/%b/%b/%b want %h/%b/%b/%b",
                     res_sum, res_carry, res_ovf, res_id, e.sum, e.carry, e.ovf, e.id);
        end
        #3;
        rst = 1'b1;
        #1;
        tests++;
        if ({req0_ready, req1_ready, res_valid, res_sum, res_carry, res_ovf, res_id, busy} !== '0) begin
            fails++;
            $display("FAIL reset_async: sum=%h v=%b c=%b o=%b id=%b busy=%b, want all 0",
                     res_sum, res_valid, res_carry, res_ovf, res_id, busy);
        end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic ok;
        exp_t e;
        res_ready = 1'b1;
        issue(1'b0, 16'h1234, 16'h0FFF, '{sum: 16'h2233, carry: 1'b0, ovf: 1'b0, id: 1'b0}, ok);
        wait_valid(ok);
        tests++;
        if (cyc - acc_cyc != WORDS + 1) begin
            fails++;
            $display("FAIL basic_latency: got %0d cycles, want %0d", cyc - acc_cyc, WORDS + 1);
        end
        e = sb.pop_front();
        tests++;
        if (res_sum !== e.sum || res_carry !== e.carry || res_ovf !== e.ovf || res_id !== e.id) begin
            fails++;
            $display("FAIL basic_result: got %h/%b/%b/%b want %h/%b/%b/%b",
                     res_sum, res_carry, res_ovf, res_id, e.sum, e.carry, e.ovf, e.id);
        end
        step();
        tests++;
        if (res_valid !== 1'b0) begin
            fails++;
            $display("FAIL basic_drop: res_valid=%b after handshake, want 0", res_valid);
        end
    endtask

    task automatic test_boundary();
        logic [W-1:0] ta[3] = '{16'hFFFF, 16'h7FFF, 16'h8000};
        logic [W-1:0] tb[3] = '{16'h0001, 16'h0001, 16'h8000};
        exp_t         te[3] = '{'{16'h0000, 1'b1, 1'b0, 1'b0},
                                '{16'h8000, 1'b0, 1'b1, 1'b0},
                                '{16'h0000, 1'b1, 1'b1, 1'b0}};
        logic ok;
        exp_t e;
        res_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, ta[i], tb[i], te[i], ok);
            wait_valid(ok);
            e = sb.pop_front();
            tests++;
            if (res_sum !== e.sum || res_carry !== e.carry || res_ovf !== e.ovf || res_id !== e.id) begin
                fails++;
                $display("FAIL boundary_%0d: got %h/%b/%b/%b want %h/%b/%b/%b", i,
                         res_sum, res_carry, res_ovf, res_id, e.sum, e.carry, e.ovf, e.id);
            end
            step();
        end
    endtask

    task automatic test_arbitration();
        logic exp_g[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic ok;
        logic gid;
        exp_t e;
        do_reset();
        res_ready  = 1'b1;
        req0_a = 16'($urandom); req0_b = 16'($urandom);
        req1_a = 16'($urandom); req1_b = 16'($urandom);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int g = 0; g < 5; g++) begin
            if (g == 4) req0_valid = 1'b0;
            #1;
            for (int i = 0; i < 20 && !(req0_ready || req1_ready); i++) step();
            tests++;
            if (!(req0_ready || req1_ready) || req1_ready !== exp_g[g]) begin
                fails++;
                $display("FAIL arb_grant_%0d: r0=%b r1=%b, want grant to req%0d",
                         g, req0_ready, req1_ready, exp_g[g]);
            end
            gid = req1_ready;
            sb.push_back(gid ? model(1'b1, req1_a, req1_b) : model(1'b0, req0_a, req0_b));
            step();
            if (gid) begin req1_a = 16'($urandom); req1_b = 16'($urandom); end
            else     begin req0_a = 16'($urandom); req0_b = 16'($urandom); end
            wait_valid(ok);
            e = sb.pop_front();
            tests++;
            if (res_sum !== e.sum || res_carry !== e.carry || res_ovf !== e.ovf || res_id !== e.id) begin
                fails++;
                $display("FAIL arb_result_%0d: got %h/%b/%b/%b want %h/%b/%b/%b", g,
                         res_sum, res_carry, res_ovf, res_id, e.sum, e.carry, e.ovf, e.id);
            end
            step();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        logic ok;
        exp_t e;
        res_ready = 1'b0;
        issue(1'b0, 16'hA5A5, 16'h5A5B, model(1'b0, 16'hA5A5, 16'h5A5B), ok);
        wait_valid(ok);
        e = sb.pop_front();
        req1_a = 16'h0F0F;
        req1_b = 16'hF0F1;
        req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) res_ready = 1'b1;
            #1;
            tests++;
            if (res_valid !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0 ||
                res_sum !== e.sum || res_carry !== e.carry || res_ovf !== e.ovf || res_id !== e.id) begin
                fails++;
                $display("FAIL bp_hold_%0d: v=%b r0=%b r1=%b got %h/%b/%b/%b want v=1 r=0 %h/%b/%b/%b", i,
                         res_valid, req0_ready, req1_ready, res_sum, res_carry, res_ovf, res_id,
                         e.sum, e.carry, e.ovf, e.id);
            end
            step();
        end
        tests++;
        if (res_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_release: res_valid=%b after 4th cycle, want 0", res_valid);
        end
        issue(1'b1, 16'h0F0F, 16'hF0F1, model(1'b1, 16'h0F0F, 16'hF0F1), ok);
        wait_valid(ok);
        e = sb.pop_front();
        tests++;
        if (res_sum !== e.sum || res_carry !== e.carry || res_ovf !== e.ovf || res_id !== e.id) begin
            fails++;
            $display("FAIL bp_next: got %h/%b/%b/%b want %h/%b/%b/%b",
                     res_sum, res_carry, res_ovf, res_id, e.sum, e.carry, e.ovf, e.id);
        end
        step();
    endtask

    task automatic test_reset_run();
        logic ok;
        logic seen;
        exp_t e;
        res_ready = 1'b1;
        issue(1'b0, 16'h4321, 16'h1111, model(1'b0, 16'h4321, 16'h1111), ok);
        step();
        step();
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        tests++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            fails++;
            $display("FAIL rrun_reset: busy=%b res_valid=%b, want 0/0", busy, res_valid);
        end
        step();
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (res_valid) seen = 1'b1;
        end
        tests++;
        if (seen) begin
            fails++;
            $display("FAIL rrun_discard: res_valid=1 after reset, want 0");
        end
        req1_a = 16'h1357; req1_b = 16'h2468; req1_valid = 1'b1;
        req0_a = 16'h00FF; req0_b = 16'h0001; req0_valid = 1'b1;
        #1;
        tests++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            fails++;
            $display("FAIL rrun_pref: r0=%b r1=%b, want 1/0", req0_ready, req1_ready);
        end
        issue(1'b0, 16'h00FF, 16'h0001, '{sum: 16'h0100, carry: 1'b0, ovf: 1'b0, id: 1'b0}, ok);
        wait_valid(ok);
        tests++;
        if (cyc - acc_cyc != WORDS + 1) begin
            fails++;
            $display("FAIL rrun_latency: got %0d cycles, want %0d", cyc - acc_cyc, WORDS + 1);
        end
        e = sb.pop_front();
        tests++;
        if (res_sum !== e.sum || res_carry !== e.carry || res_ovf !== e.ovf || res_id !== e.id) begin
            fails++;
            $display("FAIL rrun_result: got %h/%b/%b/%b want %h/%b/%b/%b",
                     res_sum, res_carry, res_ovf, res_id, e.sum, e.carry, e.ovf, e.id);
        end
        step();
        issue(1'b1, 16'h1357, 16'h2468, model(1'b1, 16'h1357, 16'h2468), ok);
        wait_valid(ok);
        e = sb.pop_front();
        tests++;
        if (res_sum !== e.sum || res_carry !== e.carry || res_ovf !== e.ovf || res_id !== e.id) begin
            fails++;
            $display("FAIL rrun_req1: got %h/%b/%b/%b want %h/%b/%b/%b",
                     res_sum, res_carry, res_ovf, res_id, e.sum, e.carry, e.ovf, e.id);
        end
        step();
    endtask

    initial begin
        rst        = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_a     = '0;
        req0_b     = '0;
        req1_a     = '0;
        req1_b     = '0;
        res_ready  = 1'b0;
        test_reset();
        test_basic();
        test_boundary();
        test_arbitration();
        test_backpressure();
        test_reset_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
